// File: rtl/delta_hadamard.sv
// Element-wise fixed-point multiply of the error vector and the activation-derivative vector.
// Optional build macro DELTA_HADAMARD_SATURATE_EN clamps overflowing cells; otherwise they wrap.
module delta_hadamard #(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION_WIDTH    = 4,
  parameter int TILING            = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a,
  input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                   valid,
  output logic                                   error,
  output logic                                   dbg_state_o
);

  localparam int AW       = A_CELL_WIDTH;
  localparam int BW       = B_CELL_WIDTH;
  localparam int RW       = RESULT_CELL_WIDTH;
  localparam int PW       = AW + BW;
  localparam int N_GROUPS = (VECTOR_LEN + TILING - 1) / TILING;
  localparam int GW       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

  // Handshake: start is a level request honoured only in IDLE; valid is a held
  // level that stays high until the next accepted start or reset.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [GW-1:0]            group_q, group_d;
  logic [VECTOR_LEN*AW-1:0] a_q, a_d;
  logic [VECTOR_LEN*BW-1:0] b_q, b_d;
  logic [VECTOR_LEN*RW-1:0] result_q, result_d;
  logic                     valid_q, valid_d;
  logic                     error_q, error_d;

  logic signed [AW-1:0] lane_a    [TILING];
  logic signed [BW-1:0] lane_b    [TILING];
  logic                 lane_act  [TILING];
  logic signed [PW-1:0] lane_prod [TILING];
  logic signed [PW-1:0] lane_shr  [TILING];
  logic                 lane_ovf  [TILING];
  logic [RW-1:0]        lane_res  [TILING];

  // Route the cells of the current group onto the shared multipliers.
  always_comb begin
    for (int j = 0; j < TILING; j++) begin
      lane_a[j]   = '0;
      lane_b[j]   = '0;
      lane_act[j] = 1'b0;
    end
    for (int i = 0; i < VECTOR_LEN; i++) begin
      if (group_q == GW'(i / TILING)) begin
        lane_a[i % TILING]   = a_q[i*AW +: AW];
        lane_b[i % TILING]   = b_q[i*BW +: BW];
        lane_act[i % TILING] = 1'b1;
      end
    end
  end

  // Full-width product, floor shift, then range check against the result cell.
  always_comb begin
    for (int j = 0; j < TILING; j++) begin
      lane_prod[j] = PW'(lane_a[j]) * PW'(lane_b[j]);
      lane_shr[j]  = lane_prod[j] >>> FRACTION_WIDTH;
      lane_ovf[j]  = (lane_shr[j][PW-1:RW-1] != {(PW-RW+1){lane_shr[j][RW-1]}});
`ifdef DELTA_HADAMARD_SATURATE_EN
      if (lane_ovf[j]) begin
        lane_res[j] = lane_shr[j][PW-1] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
      end else begin
        lane_res[j] = lane_shr[j][RW-1:0];
      end
`else
      lane_res[j] = lane_shr[j][RW-1:0];
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    group_d  = group_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    valid_d  = valid_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          result_d = '0;
          valid_d  = 1'b0;
          error_d  = 1'b0;
          group_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < VECTOR_LEN; i++) begin
          if (group_q == GW'(i / TILING)) begin
            result_d[i*RW +: RW] = lane_res[i % TILING];
          end
        end
        for (int j = 0; j < TILING; j++) begin
          if (lane_act[j] && lane_ovf[j]) begin
            error_d = 1'b1;
          end
        end
        if (group_q == GW'(N_GROUPS - 1)) begin
          valid_d = 1'b1;
          group_d = '0;
          state_d = IDLE;
        end else begin
          group_d = group_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      group_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      group_q  <= group_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign result      = result_q;
  assign valid       = valid_q;
  assign error       = error_q;
  assign dbg_state_o = (state_q == RUN);

endmodule

// File: tb/tb_delta_hadamard.sv
// Self-checking bench for delta_hadamard: vector table, hand-written corner sequences
// and a scoreboard queue popped whenever valid rises.
module tb_delta_hadamard;

  localparam int VL = 5;
  localparam int CW = 8;
  localparam int FW = 4;
  localparam int W  = VL*CW + 1;
`ifdef DELTA_HADAMARD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [VL*CW-1:0] a;
  logic [VL*CW-1:0] b;
  logic [VL*CW-1:0] result;
  logic             valid;
  logic             error;
  logic             dbg_state;

  int checks   = 0;
  int errors   = 0;
  int rise_cnt = 0;
  logic prev_valid = 1'b0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int a[VL];
    int b[VL];
    int r[VL];
    bit err;
  } vec_t;
  vec_t vecs[7];

  delta_hadamard dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .result      (result),
    .valid       (valid),
    .error       (error),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VL*CW-1:0] pack(input int v[VL]);
    logic [VL*CW-1:0] p;
    p = '0;
    for (int i = 0; i < VL; i++) p[i*CW +: CW] = CW'(v[i]);
    return p;
  endfunction

  // Reference model in plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [VL*CW-1:0] av, input logic [VL*CW-1:0] bv);
    logic [VL*CW-1:0] r;
    logic             e;
    logic signed [CW-1:0] ca, cb;
    int pa, pb, s;
    r = '0;
    e = 1'b0;
    for (int i = 0; i < VL; i++) begin
      ca = av[i*CW +: CW];
      cb = bv[i*CW +: CW];
      pa = ca;
      pb = cb;
      s  = (pa * pb) >>> FW;
      if (s > 127 || s < -128) begin
        e = 1'b1;
        if (SAT) s = (s > 0) ? 127 : -128;
      end
      r[i*CW +: CW] = s[CW-1:0];
    end
    return {e, r};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: pop one expected record on every rising edge of valid.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got result %h with empty expected queue", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e[VL*CW-1:0]) begin
          errors++;
          $display("FAIL result: got %h expected %h", result, e[VL*CW-1:0]);
        end
        checks++;
        if (error !== e[W-1]) begin
          errors++;
          $display("FAIL error_flag: got %0b expected %0b", error, e[W-1]);
        end
      end
    end
    prev_valid = valid;
  end

  // Driver tasks
  task automatic start_run(input logic [VL*CW-1:0] av, input logic [VL*CW-1:0] bv, input logic [W-1:0] expv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int cyc;
    cyc = 0;
    while (valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check(name, cyc, 3);
  endtask

  initial begin
    logic [VL*CW-1:0] ra, rb;
    int cyc, hi, rise0;

    vecs[0].a = '{16, 32, -16, 8, 0};    vecs[0].b = '{16, 8, 16, -32, 5};
    vecs[0].r = '{16, 16, -16, -16, 0};  vecs[0].err = 1'b0;
    vecs[1].a = '{127, 0, 0, 0, 0};      vecs[1].b = '{127, 0, 0, 0, 0};
    vecs[1].r = '{SAT ? 127 : -16, 0, 0, 0, 0}; vecs[1].err = 1'b1;
    vecs[2].a = '{-1, 0, 0, 0, 0};       vecs[2].b = '{1, 0, 0, 0, 0};
    vecs[2].r = '{-1, 0, 0, 0, 0};       vecs[2].err = 1'b0;
    vecs[3].a = '{1, 0, 0, 0, 0};        vecs[3].b = '{1, 0, 0, 0, 0};
    vecs[3].r = '{0, 0, 0, 0, 0};        vecs[3].err = 1'b0;
    vecs[4].a = '{0, 0, 0, 0, -128};     vecs[4].b = '{0, 0, 0, 0, 127};
    vecs[4].r = '{0, 0, 0, 0, SAT ? -128 : 8}; vecs[4].err = 1'b1;
    vecs[5].a = '{0, 64, -128, 64, 0};   vecs[5].b = '{0, 32, 16, 31, 0};
    vecs[5].r = '{0, SAT ? 127 : -128, -128, 124, 0}; vecs[5].err = 1'b1;
    vecs[6].a = '{-128, -128, -128, -128, -128}; vecs[6].b = '{-128, -128, -128, -128, -128};
    vecs[6].r = '{SAT ? 127 : 0, SAT ? 127 : 0, SAT ? 127 : 0, SAT ? 127 : 0, SAT ? 127 : 0};
    vecs[6].err = 1'b1;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_result", result, 0);
    check("reset_valid", valid, 0);
    check("reset_error", error, 0);
    check("reset_state", dbg_state, 0);

    for (int v = 0; v < 7; v++) begin
      start_run(pack(vecs[v].a), pack(vecs[v].b), {vecs[v].err, pack(vecs[v].r)});
      wait_valid($sformatf("latency_vec%0d", v));
    end

    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < VL; i++) begin
        ra[i*CW +: CW] = CW'($urandom_range(0, 255));
        rb[i*CW +: CW] = CW'($urandom_range(0, 255));
      end
      start_run(ra, rb, model(ra, rb));
      wait_valid("latency_random");
    end

    // Busy: operands change and start pulses during RUN.
    @(negedge clk);
    a = pack(vecs[0].a); b = pack(vecs[0].b); start = 1'b1;
    exp_q.push_back({vecs[0].err, pack(vecs[0].r)});
    @(negedge clk);
    a = pack(vecs[6].a); b = pack(vecs[6].b); start = 1'b1;
    cyc = 0;
    while (valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) start = 1'b0;
    end
    start = 1'b0;
    check("latency_busy", cyc, 3);
    repeat (6) @(negedge clk);
    check("busy_valid_held", valid, 1);
    check("busy_state_idle", dbg_state, 0);

    // Reset two cycles after start discards the run.
    @(negedge clk);
    a = pack(vecs[1].a); b = pack(vecs[1].b); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_result", result, 0);
    check("midrst_valid", valid, 0);
    check("midrst_error", error, 0);
    check("midrst_state", dbg_state, 0);
    start_run(pack(vecs[0].a), pack(vecs[0].b), {vecs[0].err, pack(vecs[0].r)});
    wait_valid("latency_after_rst");

    // Back-to-back: start held for 8 cycles gives two results, one every 4 cycles.
    @(negedge clk);
    a = pack(vecs[0].a); b = pack(vecs[0].b); start = 1'b1;
    exp_q.push_back({vecs[0].err, pack(vecs[0].r)});
    exp_q.push_back({vecs[0].err, pack(vecs[0].r)});
    rise0 = rise_cnt;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid === 1'b1) hi++;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("b2b_valid_high_cycles", hi, 2);
    check("b2b_results", rise_cnt - rise0, 2);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delta_hadamard.md
# delta_hadamard

Element-wise fixed-point multiply stage downstream of the matrix-vector multiplier in the backpropagation path. It forms the hidden-layer delta, delta = (Wᵀ·δ_next) ⊙ f'(z). The back-propagated error vector from the matrix-vector multiplier is multiplied cell-by-cell with the activation-derivative vector. Products are time-multiplexed over a configurable number of multipliers and written to a held result buffer with a sticky overflow flag.

## Interface
- VECTOR_LEN, 5: number of cells in each vector
- A_CELL_WIDTH, 8: signed width of error-vector cells
- B_CELL_WIDTH, 8: signed width of derivative-vector cells
- RESULT_CELL_WIDTH, 8: signed width of result cells
- FRACTION_WIDTH, 4: fraction bits shared by all operands and results
- TILING, 2: multipliers instantiated; cells processed per cycle
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  VECTOR_LEN*A_CELL_WIDTH  error vector (mvm result); cell i at [i*A_CELL_WIDTH +: A_CELL_WIDTH]
- b  input  VECTOR_LEN*B_CELL_WIDTH  activation-derivative vector, same packing
- result  output  VECTOR_LEN*RESULT_CELL_WIDTH  delta vector, same packing
- valid  output  1  result complete and stable
- error  output  1  at least one cell overflowed in the current or last run

## Operation
- States: IDLE, RUN.
- Reset: state=IDLE, group counter=0, result=0, valid=0, error=0, operand latches=0.
- IDLE with start=1:
  - Latch a and b into internal registers. Upstream may change a and b from the next cycle onward.
  - Clear result, valid and error; set group=0; go to RUN.
- IDLE with start=0: hold all outputs.
- RUN, each cycle: multiplier j computes cell g*TILING+j, for j=0..TILING-1.
  - Cells with index ≥ VECTOR_LEN are ignored. No write, no error contribution.
- Arithmetic per cell:
  - Full signed product, A_CELL_WIDTH+B_CELL_WIDTH bits.
  - Arithmetic shift right by FRACTION_WIDTH; this floors toward −∞.
  - Overflow = shifted value outside the signed RESULT_CELL_WIDTH range.
  - Overflow sets error, which is sticky until the next accepted start. Result cell content is set by the Configuration section.
- RUN, last group (g = N−1, N = ceil(VECTOR_LEN/TILING)): write that group, set valid=1, return to IDLE.
- start while in RUN is ignored. It is not queued.
- valid and result are held until the next accepted start or rst.

## Timing
- Start sampled at edge k: latch at k; groups computed at edges k+1 … k+N.
- valid rises at edge k+N, so latency is N cycles from sampling start. The default configuration gives N=3.
- Back-to-back: start held high while valid=1 is accepted the same cycle. valid drops at that edge; the next result is valid N cycles later.
- Throughput: one vector per N+1 cycles with start held high.
- error is valid when valid=1. During RUN it may rise early as groups overflow.
- rst mid-RUN: at the next edge all state and outputs return to reset values. The partial result is discarded.
- The multiply path is purely combinational between registers. There is no internal pipeline stage.

## Configuration
- DELTA_HADAMARD_SATURATE_EN defined: an overflowing cell is clamped.
  - Positive overflow → 2^(RESULT_CELL_WIDTH−1)−1.
  - Negative overflow → −2^(RESULT_CELL_WIDTH−1).
- Not defined: an overflowing cell stores the low RESULT_CELL_WIDTH bits of the shifted value (wrap-around).
- error behaviour is identical in both builds.

## Test plan
All scenarios use default parameters.
- Nominal: a=[16,32,−16,8,0], b=[16,8,16,−32,5], start 1 cycle → after 3 cycles valid=1, result=[16,16,−16,−16,0], error=0.
- Overflow: a cell0=127, b cell0=127, others 0 → SATURATE_EN: result cell0=127, error=1. Without the macro: cell0=−16 (1008 wrapped), error=1.
- Rounding: a cell0=−1, b cell0=1 → result cell0=−1 (floor), error=0. a=1, b=1 → 0.
- Busy/input change: start, then change a and b and pulse start during RUN → result matches the originally latched operands. The second start is ignored; valid=1 exactly 3 cycles after the first start.
- Reset mid-run: rst asserted 2 cycles after start → result=0, valid=0, error=0. A subsequent start produces a correct result 3 cycles later.
- Back-to-back: start held high for 8 cycles with fixed operands → valid pulses high 1 cycle out of every 4. The result is identical each time; error remains 0.
